quadrature_decoder: RTL and testbench
=====================================

# quadrature_decoder

Decodes a two-channel quadrature encoder (A/B) into the `enable`/`direction` control pair consumed by the Ex3 up/down counter. It is the initiator side of that control interface: it emits one `enable` pulse per valid quadrature step, with `direction` valid in the same cycle. The raw encoder pins are synchronised and glitch-filtered first, and illegal double-edge transitions are flagged and counted.

## Interface
- `FILTER_CYCLES`, 4: consecutive cycles a synchronised level must differ from the filtered level before it is accepted; legal range ≥1.
- `ERR_W`, 8: width of the error counter.

- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `enc_a`  in  1  encoder channel A; asynchronous to `clk`.
- `enc_b`  in  1  encoder channel B; asynchronous to `clk`.
- `enable`  out  1  one-cycle pulse per valid step; wires directly to the counter's `enable`.
- `direction`  out  1  1 = up (A leads B), 0 = down; valid whenever `enable`=1.
- `err`  out  1  one-cycle pulse on an illegal transition.
- `err_count`  out  ERR_W  count of illegal transitions; saturates at all-ones.

## Operation
- **Synchroniser:** two flops per channel (`a_s`, `b_s`).
- **Filter (per channel):**
  - Counter `flt_cnt` clears whenever `x_s` equals the filtered level `x_f`.
  - Otherwise it increments.
  - When it reaches `FILTER_CYCLES-1` while `x_s` still differs from `x_f`, then `x_f` ← `x_s` and the counter clears.
  - Pulses shorter than `FILTER_CYCLES` cycles never reach `x_f`.
- **Phase:** `{a_f,b_f}`. The forward (up) sequence is 00→10→11→01→00; the reverse sequence is down.
- **Control FSM:**
  - SETTLE (reset state): `x_f` loads `x_s` directly every cycle, bypassing the filter. Settle counter runs `FILTER_CYCLES+2` cycles, then → TRACK. Outputs are quiet.
  - TRACK: compare the current phase with the phase registered on the previous cycle.
    - Unchanged: `enable`=0, `direction` holds.
    - Forward step: `enable`=1, `direction`=1.
    - Reverse step: `enable`=1, `direction`=0.
    - Both bits changed: `err`=1, `enable`=0, `direction` holds, `err_count` += 1 (saturating). The new phase is adopted as the reference.
- **Ordering:** both filters may update in the same cycle; this is the source of the illegal case above. No transition is ever decoded from the reset phase; SETTLE guarantees this.

## Timing
- **Reset values:**
  - Outputs: `enable`=0, `direction`=1, `err`=0, `err_count`=0.
  - Internal: synchroniser flops, `a_f`/`b_f` and filter counters all 0; FSM=SETTLE with settle counter 0.
- **`rst` mid-operation:** takes effect at the next edge. Any in-progress filter count is discarded, and SETTLE is re-entered.
- **Latency:** an input change sampled at edge N reaches `a_s` at N+2 and is accepted into `x_f` at N+1+FILTER_CYCLES+1. `enable`/`err` are registered one edge later, so the total is FILTER_CYCLES+3 edges.
- **Output width:** `enable` and `err` are exactly one cycle wide and never asserted together.
- **Step rate:** maximum decodable rate is one step per `FILTER_CYCLES` cycles per channel; faster input is filtered away or flagged.
- **`err_count` saturation:** at 2^ERR_W−1, `err` still pulses but the count holds.

## Structure
- **Shared package:** FSM state encoding (SETTLE, TRACK) and phase constants for the forward-sequence lookup (next-up phase for each of the four phases).
- **Sub-module `quad_filter`:** one instance per channel, containing the two-flop synchroniser, filter counter and `x_f` register. Ports: `clk`, `rst`, `bypass` (asserted in SETTLE), `din`, `dout`.
- **Top level:** FSM, phase compare, output registers and error counter.

## Test plan
Conditions: FILTER_CYCLES=4, 10 ns clock.
1. **Reset/settle:** hold `enc_a`=1, `enc_b`=1, pulse `rst`, then idle 20 cycles → `enable`=0 and `err`=0 throughout; `direction`=1, `err_count`=0.
2. **Count up:** from 00, apply 10,11,01,00, each held 10 cycles → exactly 4 `enable` pulses with `direction`=1, the first arriving 7 edges after A rises. A driven Ex3 counter goes 0→4.
3. **Count down:** from 00, apply 01,11,10,00 → 4 pulses with `direction`=0; counter 4→0.
4. **Glitch reject:** a 3-cycle pulse on `enc_a` → no `enable`, no `err`. A 4-cycle pulse → one up step followed by one down step.
5. **Illegal transition:** from 00, switch both inputs to 11 on the same edge → one `err` pulse, `enable`=0, `err_count`=1. A following 01 decodes as up.
6. **Saturation and mid-run reset:**
   - Force 260 illegal transitions → `err_count`=255, holding.
   - Assert `rst` during a filter count → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/quadrature_decoder_pkg.sv
// Purpose: shared types and phase tables for the quadrature decoder.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// The phase is {a_f, b_f}. The forward (up) sequence is 00 -> 10 -> 11 -> 01 -> 00.
// The reverse sequence is down. A phase change that flips both bits is illegal.
package quadrature_decoder_pkg;

    // Control FSM: SETTLE lets the filters track the pins directly after reset,
    // and TRACK decodes steps.
    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_TRACK  = 1'b1
    } state_t;

    // Filtered encoder phase {a_f, b_f}.
    typedef logic [1:0] phase_t;

    localparam phase_t PH_00 = 2'b00;
    localparam phase_t PH_10 = 2'b10;
    localparam phase_t PH_11 = 2'b11;
    localparam phase_t PH_01 = 2'b01;

    // Phase that follows p when the encoder turns one step forward.
    function automatic phase_t next_up(input phase_t p);
        phase_t n;
        case (p)
            PH_00:   n = PH_10;
            PH_10:   n = PH_11;
            PH_11:   n = PH_01;
            default: n = PH_00;
        endcase
        return n;
    endfunction

    // Phase that follows p when the encoder turns one step in reverse.
    function automatic phase_t next_down(input phase_t p);
        phase_t n;
        case (p)
            PH_00:   n = PH_01;
            PH_01:   n = PH_11;
            PH_11:   n = PH_10;
            default: n = PH_00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Purpose: bundles the encoder pins and the decoded counter-control outputs.
// Latency: n/a (wires only).
// Backpressure: none; enable/err are fire-and-forget pulses.
//
// Signals:
//   enc_a, enc_b : raw encoder channels, asynchronous to clk
//   enable       : one-cycle pulse per valid step, feeds the counter's enable
//   direction    : 1 = up (A leads B), 0 = down; valid while enable = 1
//   err          : one-cycle pulse on an illegal double-edge transition
//   err_count    : saturating count of illegal transitions
// master = decoder side, slave = pin source / counter side.
interface quadrature_decoder_if #(
    parameter int ERR_W = 8
);
    logic             enc_a;
    logic             enc_b;
    logic             enable;
    logic             direction;
    logic             err;
    logic [ERR_W-1:0] err_count;

    modport master (
        input  enc_a,
        input  enc_b,
        output enable,
        output direction,
        output err,
        output err_count
    );

    modport slave (
        output enc_a,
        output enc_b,
        input  enable,
        input  direction,
        input  err,
        input  err_count
    );
endinterface

// File: rtl/quad_filter.sv
// Purpose: one encoder channel. It has a two-flop synchroniser and a persistence filter.
// Latency: 2 edges to din_s, then FILTER_CYCLES edges of persistence before dout updates.
// Backpressure: none; din is sampled every cycle.
//
// Ports:
//   clk, rst : system clock and synchronous active-high reset
//   bypass   : when set, dout follows the synchronised input every cycle
//   din      : raw asynchronous channel input
//   dout     : filtered level (x_f)
module quad_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic bypass,
    input  logic din,
    output logic dout
);

    // The counter must hold 0 .. FILTER_CYCLES-1.
    localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic             sync_1;
    logic             din_s;
    logic [CNT_W-1:0] flt_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1  <= 1'b0;
            din_s   <= 1'b0;
            dout    <= 1'b0;
            flt_cnt <= '0;
        end else begin
            sync_1 <= din;
            din_s  <= sync_1;
            if (bypass) begin
                dout    <= din_s;
                flt_cnt <= '0;
            end else if (din_s == dout) begin
                // Any return to the accepted level restarts the persistence count.
                flt_cnt <= '0;
            end else if (flt_cnt == CNT_LAST) begin
                // The level has now differed for FILTER_CYCLES consecutive samples.
                dout    <= din_s;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/quadrature_decoder.sv
// Purpose: decodes filtered quadrature A/B into enable/direction steps and flags illegal transitions.
// Latency: FILTER_CYCLES+3 edges from a pin change to the enable/err pulse.
// Backpressure: none; outputs are single-cycle pulses that the consumer must take.
//
// Ports:
//   clk, rst : system clock and synchronous active-high reset
//   bus      : master side of quadrature_decoder_if (enc_a/enc_b in; enable, direction,
//              err, err_count out)
module quadrature_decoder
    import quadrature_decoder_pkg::*;
#(
    parameter int FILTER_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    quadrature_decoder_if.master        bus
);

    // SETTLE lasts FILTER_CYCLES+2 cycles. This lets the synchronisers fill and
    // the bypassed filters pick up the live pin levels before any decoding starts.
    localparam int SETTLE_W = $clog2(FILTER_CYCLES + 2) + 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(FILTER_CYCLES + 1);

    state_t              state;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                bypass;

    logic                a_f;
    logic                b_f;
    phase_t              phase;
    phase_t              prev_phase;

    logic                is_up;
    logic                is_down;
    logic                is_illegal;

    logic                enable_q;
    logic                direction_q;
    logic                err_q;
    logic [ERR_W-1:0]    err_count_q;

    assign bypass = (state == ST_SETTLE);

    quad_filter #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filt_a (
        .clk    (clk),
        .rst    (rst),
        .bypass (bypass),
        .din    (bus.enc_a),
        .dout   (a_f)
    );

    quad_filter #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filt_b (
        .clk    (clk),
        .rst    (rst),
        .bypass (bypass),
        .din    (bus.enc_b),
        .dout   (b_f)
    );

    assign phase = {a_f, b_f};

    // Classify the change between last cycle's phase and this cycle's phase.
    // Both filters can update on the same edge. That flips both bits, which is the only
    // illegal case.
    always_comb begin
        is_up      = (phase == next_up(prev_phase));
        is_down    = (phase == next_down(prev_phase));
        is_illegal = ((phase ^ prev_phase) == 2'b11);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_SETTLE;
            settle_cnt  <= '0;
            prev_phase  <= PH_00;
            enable_q    <= 1'b0;
            direction_q <= 1'b1;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            enable_q   <= 1'b0;
            err_q      <= 1'b0;
            // The reference phase follows the filters in both states. The first
            // TRACK compare therefore never sees the reset phase.
            prev_phase <= phase;
            case (state)
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_TRACK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (is_up) begin
                        enable_q    <= 1'b1;
                        direction_q <= 1'b1;
                    end else if (is_down) begin
                        enable_q    <= 1'b1;
                        direction_q <= 1'b0;
                    end else if (is_illegal) begin
                        // direction holds. The new phase is adopted via prev_phase above.
                        err_q <= 1'b1;
                        if (err_count_q != '1) begin
                            err_count_q <= err_count_q + 1'b1;
                        end
                    end
                end
                default: state <= ST_SETTLE;
            endcase
        end
    end

    assign bus.enable    = enable_q;
    assign bus.direction = direction_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Purpose: self-checking bench for quadrature_decoder (table vectors, corner sequences, random steps).
// Latency: expects every accepted pin change to surface FILTER_CYCLES+3 edges later.
// Backpressure: n/a.
module tb_quadrature_decoder;
    import quadrature_decoder_pkg::*;

    localparam int FC  = 4;
    localparam int LAT = FC + 3;
    localparam int EVN = 16384;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    quadrature_decoder_if #(.ERR_W(8)) qif ();

    quadrature_decoder #(
        .FILTER_CYCLES (FC),
        .ERR_W         (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (qif)
    );

    int checks = 0;
    int errors = 0;

    int   cyc   = 0;
    logic rst_q = 1'b1;

    // Expected output event per edge: 0 none, 1 up, 2 down, 3 illegal.
    logic [1:0] ev [EVN];

    // Reference model state
    logic [1:0] m_phase;     // last pin phase driven (what the filters will accept)
    logic       m_dir = 1'b1;
    int         m_cnt = 0;
    logic       e_en  = 1'b0;
    logic       e_err = 1'b0;
    int         mpos  = 0;

    // Observed activity (stands in for the downstream up/down counter)
    int   en_pulses   = 0;
    int   err_pulses  = 0;
    int   pos         = 0;
    int   last_en_cyc = 0;
    logic last_dir    = 1'b1;
    logic chk_on      = 1'b0;

    // Position of a phase along the forward cycle 00,10,11,01.
    function automatic int idx(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ph_of(input int i);
        case (i & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Per-cycle model and compare, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_q) begin
            m_dir = 1'b1;
            m_cnt = 0;
            e_en  = 1'b0;
            e_err = 1'b0;
        end else begin
            e_en  = 1'b0;
            e_err = 1'b0;
            case (ev[cyc % EVN])
                2'd1: begin e_en = 1'b1; m_dir = 1'b1; end
                2'd2: begin e_en = 1'b1; m_dir = 1'b0; end
                2'd3: begin e_err = 1'b1; if (m_cnt < 255) m_cnt = m_cnt + 1; end
                default: ;
            endcase
        end
        if (qif.enable === 1'b1) begin
            en_pulses   = en_pulses + 1;
            last_dir    = qif.direction;
            last_en_cyc = cyc;
            pos         = pos + (qif.direction ? 1 : -1);
        end
        if (qif.err === 1'b1) err_pulses = err_pulses + 1;
        if (chk_on) begin
            checks = checks + 1;
            if (qif.enable !== e_en || qif.err !== e_err || qif.direction !== m_dir ||
                qif.err_count !== 8'(m_cnt)) begin
                errors = errors + 1;
                $display("FAIL model cycle %0d: got en=%b err=%b dir=%b cnt=%0d expected en=%b err=%b dir=%b cnt=%0d",
                         cyc, qif.enable, qif.err, qif.direction, qif.err_count,
                         e_en, e_err, m_dir, m_cnt);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic drive(input logic [1:0] p);
        @(posedge clk);
        #1;
        qif.enc_a = p[1];
        qif.enc_b = p[0];
    endtask

    task automatic clear_ev();
        for (int i = 0; i < EVN; i++) ev[i] = 2'd0;
    endtask

    // Drive a new phase, hold it `hold` cycles, and schedule the model's expected event.
    task automatic step_to(input logic [1:0] p, input int hold, output int c);
        int d;
        drive(p);
        c = cyc;
        d = (idx(p) - idx(m_phase)) & 3;
        if (d == 1) begin
            ev[(c + LAT) % EVN] = 2'd1;
            mpos = mpos + 1;
        end else if (d == 3) begin
            ev[(c + LAT) % EVN] = 2'd2;
            mpos = mpos - 1;
        end else if (d == 2) begin
            ev[(c + LAT) % EVN] = 2'd3;
        end
        m_phase = p;
        idle(hold - 1);
    endtask

    // Short pulse on one channel that must never be accepted (len < FC).
    task automatic glitch(input int ch, input int len);
        logic [1:0] g;
        g = m_phase ^ ((ch != 0) ? 2'b01 : 2'b10);
        drive(g);
        idle(len - 1);
        drive(m_phase);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_ev();
        idle(3);
        #1;
        chk_on  = 1'b1;
        rst     = 1'b0;
        m_phase = {qif.enc_a, qif.enc_b};
        idle(20);
    endtask

    typedef struct {
        logic [1:0] ph;
        int         en_n;
        logic       dir;
        int         err_n;
        int         pos;
        int         ecnt;
    } vec_t;

    initial begin
        vec_t tbl [11];
        int   c;
        int   e0;
        int   r0;
        int   p0;

        tbl[0]  = '{2'b10, 1, 1'b1, 0, 1, 0};
        tbl[1]  = '{2'b11, 1, 1'b1, 0, 2, 0};
        tbl[2]  = '{2'b01, 1, 1'b1, 0, 3, 0};
        tbl[3]  = '{2'b00, 1, 1'b1, 0, 4, 0};
        tbl[4]  = '{2'b01, 1, 1'b0, 0, 3, 0};
        tbl[5]  = '{2'b11, 1, 1'b0, 0, 2, 0};
        tbl[6]  = '{2'b10, 1, 1'b0, 0, 1, 0};
        tbl[7]  = '{2'b00, 1, 1'b0, 0, 0, 0};
        tbl[8]  = '{2'b11, 0, 1'b0, 1, 0, 1};
        tbl[9]  = '{2'b01, 1, 1'b1, 0, 1, 1};
        tbl[10] = '{2'b00, 1, 1'b1, 0, 2, 1};

        clear_ev();
        qif.enc_a = 1'b1;
        qif.enc_b = 1'b1;
        m_phase   = 2'b11;

        // Reset and settle with the pins held at 11.
        do_reset();
        #1;
        check("settle_enable_pulses", en_pulses, 0);
        check("settle_err_pulses", err_pulses, 0);
        check("settle_direction", int'(qif.direction), 1);
        check("settle_err_count", int'(qif.err_count), 0);

        // Move the pins to 00 under reset, then run the table.
        @(posedge clk);
        #1;
        qif.enc_a = 1'b0;
        qif.enc_b = 1'b0;
        do_reset();
        pos = 0;
        for (int i = 0; i < 11; i++) begin
            e0 = en_pulses;
            r0 = err_pulses;
            step_to(tbl[i].ph, 10, c);
            #1;
            check($sformatf("row%0d_enable_pulses", i), en_pulses - e0, tbl[i].en_n);
            check($sformatf("row%0d_err_pulses", i), err_pulses - r0, tbl[i].err_n);
            check($sformatf("row%0d_direction", i), int'(qif.direction), int'(tbl[i].dir));
            check($sformatf("row%0d_counter", i), pos, tbl[i].pos);
            check($sformatf("row%0d_err_count", i), int'(qif.err_count), tbl[i].ecnt);
            if (tbl[i].en_n == 1)
                check($sformatf("row%0d_latency", i), last_en_cyc - c, LAT);
        end

        // A 3-cycle pulse on A is rejected.
        e0 = en_pulses;
        r0 = err_pulses;
        glitch(0, 3);
        idle(15);
        #1;
        check("glitch3_enable_pulses", en_pulses - e0, 0);
        check("glitch3_err_pulses", err_pulses - r0, 0);

        // A 4-cycle pulse on A is accepted: one up step, then one down step.
        e0 = en_pulses;
        p0 = pos;
        step_to(2'b10, 4, c);
        step_to(2'b00, 15, c);
        #1;
        check("pulse4_enable_pulses", en_pulses - e0, 2);
        check("pulse4_counter_delta", pos - p0, 0);
        check("pulse4_last_direction", int'(last_dir), 0);

        // Saturate the error counter.
        do_reset();
        r0 = err_pulses;
        for (int i = 0; i < 260; i++) step_to((i % 2 == 0) ? 2'b11 : 2'b00, 5, c);
        idle(10);
        #1;
        check("sat_err_pulses", err_pulses - r0, 260);
        check("sat_err_count", int'(qif.err_count), 255);
        step_to(2'b01, 10, c);
        #1;
        check("sat_then_down_direction", int'(qif.direction), 0);

        // Reset while the A filter is still counting.
        step_to(2'b11, 4, c);
        #1;
        rst = 1'b1;
        clear_ev();
        @(posedge clk);
        #1;
        check("midrst_enable", int'(qif.enable), 0);
        check("midrst_err", int'(qif.err), 0);
        check("midrst_direction", int'(qif.direction), 1);
        check("midrst_err_count", int'(qif.err_count), 0);
        rst     = 1'b0;
        m_phase = {qif.enc_a, qif.enc_b};
        idle(20);

        // Randomised steps, illegal jumps and glitches.
        do_reset();
        pos  = 0;
        mpos = 0;
        for (int i = 0; i < 300; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                step_to(ph_of(idx(m_phase) + 1), $urandom_range(4, 12), c);
            end else if (op <= 6) begin
                step_to(ph_of(idx(m_phase) + 3), $urandom_range(4, 12), c);
            end else if (op == 7) begin
                step_to(m_phase ^ 2'b11, $urandom_range(4, 12), c);
            end else begin
                glitch($urandom_range(0, 1), $urandom_range(1, FC - 1));
                idle($urandom_range(1, 6));
            end
        end
        idle(20);
        #1;
        check("random_counter_position", pos, mpos);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
